// File: rtl/fp_pkg.sv
// Shared constants and IEEE-754 single-precision word layout for the float datapath.
package fp_pkg;

    localparam int BIAS       = 127;  // IEEE single exponent bias
    localparam int EXP_MAX    = 255;  // all-ones exponent field (Inf)
    localparam int MANT_W     = 23;   // stored fraction width
    localparam int HIDDEN_BIT = 30;   // hidden-one position in the 32-bit working mantissa
    localparam int KEEP_LO    = 7;    // lowest kept bit after normalisation
    localparam int GUARD_BIT  = 6;
    localparam int ROUND_BIT  = 5;
    localparam int STICKY_HI  = 4;    // bits [STICKY_HI:0] collapse into sticky

    typedef struct packed {
        logic              sign;
        logic [7:0]        exp;
        logic [MANT_W-1:0] mant;
    } ieee_t;

endpackage

// File: rtl/fp_lzc31.sv
// Combinational leading-zero counter over a 31-bit field (MSB = bit 30).
module fp_lzc31 (
    input  logic [30:0] din,
    output logic [4:0]  cnt,
    output logic        zero
);

    // Scan upward so the highest set bit determines the final count.
    always_comb begin
        cnt  = '0;
        zero = ~|din;
        for (int unsigned i = 0; i < 31; i++) begin
            if (din[i]) begin
                cnt = 5'(30 - i);
            end
        end
    end

endmodule

// File: rtl/ls_L.sv
// Shared 32-bit logical left shifter used across the float datapath.
module ls_L (
    input  logic [31:0] din,
    input  logic [4:0]  shamt,
    output logic [31:0] dout
);

    // Zero-filling left shift.
    always_comb begin
        dout = din << shamt;
    end

endmodule

// File: rtl/fp_normalizer.sv
// Three-stage normalize / round-to-nearest-even / pack pipeline for single-precision results.
module fp_normalizer #(
    parameter int BIAS  = 127,
    parameter int EXP_W = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sign,
    input  logic [EXP_W-1:0] in_exp,
    input  logic [31:0]      in_mant,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic             out_ovf,
    output logic             out_unf,
    output logic             out_inx
);

    import fp_pkg::*;

    localparam int EW = EXP_W + 1;
    typedef logic signed [EW-1:0] sexp_t;

    // All stages move in lockstep; a stalled output freezes the whole pipe.
    logic advance;
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // ---------------- S1: classify / count ----------------
    logic [4:0]  lz;
    logic        lz_zero;
    sexp_t       exp_ext;
    sexp_t       exp_rb;
    logic [31:0] s1_mant_d;
    logic        s1_sticky_d;
    logic [4:0]  s1_sh_d;
    sexp_t       s1_exp_d;
    logic        s1_zero_d;

    fp_lzc31 u_lzc (
        .din  (in_mant[30:0]),
        .cnt  (lz),
        .zero (lz_zero)
    );

    // Sign-extend, rebase to IEEE bias, then fold in carry or leading-zero adjustment.
    always_comb begin
        exp_ext     = EW'($signed(in_exp));
        exp_rb      = exp_ext - sexp_t'(BIAS) + sexp_t'(fp_pkg::BIAS);
        s1_mant_d   = in_mant;
        s1_sticky_d = 1'b0;
        s1_sh_d     = '0;
        s1_exp_d    = exp_rb;
        s1_zero_d   = 1'b0;
        if (in_mant[31]) begin
            s1_mant_d   = {1'b0, in_mant[31:1]};
            s1_sticky_d = in_mant[0];
            s1_exp_d    = exp_rb + sexp_t'(1);
        end else if (lz_zero) begin
            s1_mant_d = '0;
            s1_zero_d = 1'b1;
        end else begin
            s1_sh_d  = lz;
            s1_exp_d = exp_rb - sexp_t'(lz);
        end
    end

    logic        s1_valid;
    logic [31:0] s1_mant;
    logic        s1_sticky;
    logic [4:0]  s1_sh;
    sexp_t       s1_exp;
    logic        s1_sign;
    logic        s1_zero;

    // S1 register: capture a beat only on an accepted handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_mant   <= '0;
            s1_sticky <= 1'b0;
            s1_sh     <= '0;
            s1_exp    <= '0;
            s1_sign   <= 1'b0;
            s1_zero   <= 1'b0;
        end else if (advance) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_mant   <= s1_mant_d;
                s1_sticky <= s1_sticky_d;
                s1_sh     <= s1_sh_d;
                s1_exp    <= s1_exp_d;
                s1_sign   <= in_sign;
                s1_zero   <= s1_zero_d;
            end
        end
    end

    // ---------------- S2: shift ----------------
    logic [31:0] shifted;

    ls_L u_shift (
        .din   (s1_mant),
        .shamt (s1_sh),
        .dout  (shifted)
    );

    logic        s2_valid;
    logic [30:0] s2_mant;
    logic        s2_sticky;
    sexp_t       s2_exp;
    logic        s2_sign;
    logic        s2_zero;

    // S2 register: normalised mantissa with hidden one at bit 30.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid  <= 1'b0;
            s2_mant   <= '0;
            s2_sticky <= 1'b0;
            s2_exp    <= '0;
            s2_sign   <= 1'b0;
            s2_zero   <= 1'b0;
        end else if (advance) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_mant   <= shifted[30:0];
                s2_sticky <= s1_sticky;
                s2_exp    <= s1_exp;
                s2_sign   <= s1_sign;
                s2_zero   <= s1_zero;
            end
        end
    end

    // ---------------- S3: round / pack ----------------
    logic [23:0] kept;
    logic        guard_b;
    logic        round_b;
    logic        sticky_b;
    logic        rnd_up;
    logic [24:0] sum;
    logic [22:0] frac;
    sexp_t       exp_r;
    logic        inexact;
    ieee_t       res;
    logic        res_ovf;
    logic        res_unf;
    logic        res_inx;

    // Nearest-even rounding, then range check on the full-width signed exponent.
    always_comb begin
        kept     = s2_mant[HIDDEN_BIT:KEEP_LO];
        guard_b  = s2_mant[GUARD_BIT];
        round_b  = s2_mant[ROUND_BIT];
        sticky_b = (|s2_mant[STICKY_HI:0]) | s2_sticky;
        rnd_up   = guard_b & (round_b | sticky_b | kept[0]);
        sum      = {1'b0, kept} + 25'(rnd_up);
        inexact  = guard_b | round_b | sticky_b;
        if (sum[24]) begin
            frac  = '0;
            exp_r = s2_exp + sexp_t'(1);
        end else begin
            frac  = sum[22:0];
            exp_r = s2_exp;
        end

        res      = '0;
        res.sign = s2_sign;
        res_ovf  = 1'b0;
        res_unf  = 1'b0;
        res_inx  = 1'b0;
        if (s2_zero) begin
            res_inx = 1'b0;
        end else if (exp_r >= sexp_t'(EXP_MAX)) begin
            res.exp = 8'hFF;
            res_ovf = 1'b1;
            res_inx = 1'b1;
        end else if (exp_r <= sexp_t'(0)) begin
            res_unf = 1'b1;
            res_inx = 1'b1;
        end else begin
            res.exp  = exp_r[7:0];
            res.mant = frac;
            res_inx  = inexact;
        end
    end

    // Shifter bit 31 is always clear after S1; sum[23] is the implicit hidden one.
    logic unused_bits;
    assign unused_bits = ^{shifted[31], sum[23]};

    // Output register: holds data and flags while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
            out_unf   <= 1'b0;
            out_inx   <= 1'b0;
        end else if (advance) begin
            out_valid <= s2_valid;
            if (s2_valid) begin
                out_data <= res;
                out_ovf  <= res_ovf;
                out_unf  <= res_unf;
                out_inx  <= res_inx;
            end
        end
    end

endmodule

// File: tb/tb_fp_normalizer.sv
// Scoreboard bench for fp_normalizer: driver pushes expectations, monitor pops and compares.
module tb_fp_normalizer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [9:0]  in_exp;
    logic [31:0] in_mant;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_ovf;
    logic        out_unf;
    logic        out_inx;

    fp_normalizer #(.BIAS(127), .EXP_W(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .in_exp    (in_exp),
        .in_mant   (in_mant),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf),
        .out_unf   (out_unf),
        .out_inx   (out_inx)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        s;
        logic [9:0]  e;
        logic [31:0] m;
        logic [31:0] d;
        logic        o;
        logic        u;
        logic        x;
    } vec_t;

    typedef struct packed {
        logic [31:0] d;
        logic        o;
        logic        u;
        logic        x;
        logic        lat;
        logic [31:0] issue;
    } exp_t;

    exp_t sb[$];
    vec_t vt[17];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    bit   shown  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compares the presented beat each cycle, pops on handshake.
    always @(negedge clk) begin : mon
        exp_t e;
        #2;
        if (rst_n && out_valid) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out got=%08h ovf=%0b unf=%0b inx=%0b want=none",
                         out_data, out_ovf, out_unf, out_inx);
            end else begin
                e = sb[0];
                if ({out_data, out_ovf, out_unf, out_inx} !== {e.d, e.o, e.u, e.x}) begin
                    errors++;
                    $display("FAIL result got=%08h o/u/x=%0b%0b%0b want=%08h o/u/x=%0b%0b%0b",
                             out_data, out_ovf, out_unf, out_inx, e.d, e.o, e.u, e.x);
                end
                if (!shown && e.lat) begin
                    checks++;
                    if (cyc - int'(e.issue) != 3) begin
                        errors++;
                        $display("FAIL latency got=%0d want=3", cyc - int'(e.issue));
                    end
                end
                shown = 1'b1;
                if (out_ready) begin
                    void'(sb.pop_front());
                    shown = 1'b0;
                end
            end
        end
    end

    function automatic exp_t mk_exp(input vec_t v, input logic lat, input int issue);
        exp_t e;
        e.d = v.d; e.o = v.o; e.u = v.u; e.x = v.x;
        e.lat = lat; e.issue = 32'(issue);
        return e;
    endfunction

    // Present one beat starting at a negedge; returns at the negedge after acceptance.
    task automatic send(input vec_t v, input logic lat);
        int n;
        n = 0;
        in_valid = 1'b1; in_sign = v.s; in_exp = v.e; in_mant = v.m;
        #1;
        while (!in_ready && n < 50) begin
            @(negedge clk); #1; n++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL accept_timeout got=in_ready0 want=in_ready1");
        end else begin
            sb.push_back(mk_exp(v, lat, cyc));
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        @(negedge clk); #3;
        while (sb.size() != 0 && n < 60) begin
            @(negedge clk); #3; n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout got=%0d pending want=0", sb.size());
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%08h want=%08h", name, got, want);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        int sel[6];
        vt = '{
            '{1'b0, 10'd127, 32'h4000_0000, 32'h3F80_0000, 1'b0, 1'b0, 1'b0},
            '{1'b0, 10'd127, 32'h8000_0000, 32'h4000_0000, 1'b0, 1'b0, 1'b0},
            '{1'b0, 10'd157, 32'h0000_0001, 32'h3F80_0000, 1'b0, 1'b0, 1'b0},
            '{1'b0, 10'd127, 32'h7FFF_FFC0, 32'h4000_0000, 1'b0, 1'b0, 1'b1},
            '{1'b0, 10'd127, 32'h7FFF_FF40, 32'h3FFF_FFFE, 1'b0, 1'b0, 1'b1},
            '{1'b0, 10'd255, 32'h4000_0000, 32'h7F80_0000, 1'b1, 1'b0, 1'b1},
            '{1'b1, 10'd0,   32'h4000_0000, 32'h8000_0000, 1'b0, 1'b1, 1'b1},
            '{1'b0, 10'd200, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b0},
            '{1'b1, 10'd130, 32'h6000_0000, 32'hC140_0000, 1'b0, 1'b0, 1'b0},
            '{1'b0, 10'h3FB, 32'h4000_0000, 32'h0000_0000, 1'b0, 1'b1, 1'b1},
            '{1'b0, 10'd254, 32'h8000_0000, 32'h7F80_0000, 1'b1, 1'b0, 1'b1},
            '{1'b0, 10'd254, 32'h7FFF_FFC0, 32'h7F80_0000, 1'b1, 1'b0, 1'b1},
            '{1'b0, 10'd1,   32'h4000_0000, 32'h0080_0000, 1'b0, 1'b0, 1'b0},
            '{1'b0, 10'd1,   32'h2000_0000, 32'h0000_0000, 1'b0, 1'b1, 1'b1},
            '{1'b0, 10'd127, 32'h4000_0001, 32'h3F80_0000, 1'b0, 1'b0, 1'b1},
            '{1'b0, 10'd127, 32'h8000_0001, 32'h4000_0000, 1'b0, 1'b0, 1'b1},
            '{1'b0, 10'd127, 32'h4000_00C0, 32'h3F80_0002, 1'b0, 1'b0, 1'b1}
        };

        rst_n = 1'b0; in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_mant = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_flags", 32'({out_ovf, out_unf, out_inx}), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        #3 rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);

        // Directed single beats with latency check.
        for (int i = 0; i < 17; i++) begin
            send(vt[i], 1'b1);
            drain();
        end

        // Backpressure: six back-to-back beats, consumer stalls in cycles 4..8.
        sel = '{8, 15, 16, 12, 4, 13};
        @(negedge clk);
        idx = 0;
        for (int k = 0; k < 20; k++) begin
            out_ready = !(k >= 4 && k <= 8);
            if (idx < 6) begin
                in_valid = 1'b1;
                in_sign  = vt[sel[idx]].s;
                in_exp   = vt[sel[idx]].e;
                in_mant  = vt[sel[idx]].m;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (k >= 4 && k <= 8) chk("stall_in_ready", 32'(in_ready), 32'd0);
            if (in_valid && in_ready) begin
                sb.push_back(mk_exp(vt[sel[idx]], 1'b0, cyc));
                idx++;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("bp_all_issued", 32'(idx), 32'd6);
        drain();

        // Reset mid-flight: one beat out, two still in the pipe.
        @(negedge clk);
        send(vt[1], 1'b0);
        send(vt[3], 1'b0);
        send(vt[8], 1'b0);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_data", out_data, 32'h0);
        sb.delete();
        shown = 1'b0;
        #3 rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); #1;
            chk("post_rst_idle", 32'(out_valid), 32'd0);
            chk("post_rst_ready", 32'(in_ready), 32'd1);
        end
        @(negedge clk);
        send(vt[8], 1'b1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
